// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared widths, AW payload struct and AW FSM states for the write arbiter
package axi_arb_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // id carries the master index in its top bit
    typedef struct packed {
        logic [ID_W:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [3:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
    } aw_payload_t;

    typedef enum logic {
        ARB  = 1'b0,
        SEND = 1'b1
    } aw_state_t;

endpackage

// File: rtl/axi_arb_gfifo.sv
// rtl/axi_arb_gfifo.sv - 1-bit grant-order FIFO recording which master owns each granted burst
module axi_arb_gfifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot a full-FIFO push needs
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-master AXI3 write-path arbiter: RR on AW, grant-ordered W, ID-routed B
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int GFIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   m0_awid,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic [3:0]        m0_awlen,
    input  logic [2:0]        m0_awsize,
    input  logic [1:0]        m0_awburst,
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [ID_W-1:0]   m0_wid,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic              m0_wlast,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    output logic [ID_W-1:0]   m0_bid,
    output logic [1:0]        m0_bresp,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    input  logic [ID_W-1:0]   m1_awid,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic [3:0]        m1_awlen,
    input  logic [2:0]        m1_awsize,
    input  logic [1:0]        m1_awburst,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [ID_W-1:0]   m1_wid,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic              m1_wlast,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic [ID_W-1:0]   m1_bid,
    output logic [1:0]        m1_bresp,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    output logic [ID_W:0]     s_awid,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic [3:0]        s_awlen,
    output logic [2:0]        s_awsize,
    output logic [1:0]        s_awburst,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [ID_W:0]     s_wid,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    output logic              s_wlast,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic [ID_W:0]     s_bid,
    input  logic [1:0]        s_bresp,
    input  logic              s_bvalid,
    output logic              s_bready
);

    aw_state_t   state, state_nx;
    logic        last, last_nx;
    aw_payload_t aw_q, aw_nx;
    logic        grant_idx;
    logic        gf_push;
    logic        gf_head;
    logic        gf_full;
    logic        gf_empty;
    logic        w_pop;
    logic        can_grant;
    logic        b_dst;

    axi_arb_gfifo #(.DEPTH(GFIFO_DEPTH)) u_gfifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (gf_push),
        .din   (grant_idx),
        .pop   (w_pop),
        .dout  (gf_head),
        .full  (gf_full),
        .empty (gf_empty)
    );

    assign w_pop     = s_wvalid & s_wready & s_wlast;
    assign can_grant = ~gf_full | w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
            last  <= 1'b1;
            aw_q  <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            aw_q  <= aw_nx;
        end
    end

    // rst_n gating keeps awready low while reset is held, whatever awvalid does
    always_comb begin
        state_nx   = state;
        last_nx    = last;
        aw_nx      = aw_q;
        grant_idx  = 1'b0;
        gf_push    = 1'b0;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        case (state)
            ARB: begin
                if (rst_n && can_grant && (m0_awvalid || m1_awvalid)) begin
                    grant_idx = (m0_awvalid && m1_awvalid) ? ~last : m1_awvalid;
                    gf_push   = 1'b1;
                    last_nx   = grant_idx;
                    state_nx  = SEND;
                    if (grant_idx) begin
                        m1_awready = 1'b1;
                        aw_nx = '{id: {1'b1, m1_awid}, addr: m1_awaddr, len: m1_awlen,
                                  size: m1_awsize, burst: m1_awburst};
                    end else begin
                        m0_awready = 1'b1;
                        aw_nx = '{id: {1'b0, m0_awid}, addr: m0_awaddr, len: m0_awlen,
                                  size: m0_awsize, burst: m0_awburst};
                    end
                end
            end
            SEND: begin
                if (s_awready) begin
                    state_nx = ARB;
                end
            end
            default: state_nx = ARB;
        endcase
    end

    assign s_awvalid = (state == SEND);
    assign s_awid    = aw_q.id;
    assign s_awaddr  = aw_q.addr;
    assign s_awlen   = aw_q.len;
    assign s_awsize  = aw_q.size;
    assign s_awburst = aw_q.burst;

    // W follows the grant FIFO head; the other master stays stalled
    always_comb begin
        s_wid     = gf_head ? {1'b1, m1_wid} : {1'b0, m0_wid};
        s_wdata   = gf_head ? m1_wdata : m0_wdata;
        s_wstrb   = gf_head ? m1_wstrb : m0_wstrb;
        s_wlast   = gf_head ? m1_wlast : m0_wlast;
        s_wvalid  = 1'b0;
        m0_wready = 1'b0;
        m1_wready = 1'b0;
        if (!gf_empty) begin
            s_wvalid = gf_head ? m1_wvalid : m0_wvalid;
            if (gf_head) begin
                m1_wready = s_wready;
            end else begin
                m0_wready = s_wready;
            end
        end
    end

    assign b_dst     = s_bid[ID_W];
    assign m0_bvalid = rst_n & s_bvalid & ~b_dst;
    assign m1_bvalid = rst_n & s_bvalid & b_dst;
    assign m0_bid    = s_bid[ID_W-1:0];
    assign m1_bid    = s_bid[ID_W-1:0];
    assign m0_bresp  = s_bresp;
    assign m1_bresp  = s_bresp;
    assign s_bready  = rst_n & (b_dst ? m1_bready : m0_bready);

endmodule
